// File: rtl/ram_alu_core.sv
// ram_alu_core: single-port synchronous RAM with a tri-state data bus, plus a
// 16-bit combinational ALU. The two halves share only clk and rst.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   addr              RAM word address (ADDR_WIDTH bits)
//   data              bidirectional RAM data bus (DATA_WIDTH bits)
//   cs_input, we, oe  chip select, write enable, output enable (active-high)
//   A, B, ALU_Sel     ALU operands and operation select
//                     (00 OR, 01 ADD, 10 SUB, 11 AND)
//   ALU_Out           ALU result
//   alu_zero, alu_neg, alu_carry
//                     ALU flags, present only when ALU_FLAGS_EN is defined
//
// Build option: define ALU_FLAGS_EN to compile in the ALU flag ports and logic.
module ram_alu_core #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs_input,
  input  logic                  we,
  input  logic                  oe,
  input  logic [15:0]           A,
  input  logic [15:0]           B,
  input  logic [1:0]            ALU_Sel,
  output logic [15:0]           ALU_Out
`ifdef ALU_FLAGS_EN
  ,
  output logic                  alu_zero,
  output logic                  alu_neg,
  output logic                  alu_carry
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned ALU_W = 16;

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_d;

  // Storage array: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (cs_input && we) begin
      mem_q[addr] <= data;
    end
  end

  // Read register loads only on a selected non-write edge; write wins over read.
  always_comb begin
    rd_d = rd_q;
    if (cs_input && !we) begin
      rd_d = mem_q[addr];
    end
  end

  // rst overrides a read landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  // Bus is driven only for an enabled read; we or !oe release it immediately.
  assign data = (cs_input && oe && !we) ? rd_q : {DATA_WIDTH{1'bz}};

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  // Bit 16 holds carry-out for ADD and borrow (A < B unsigned) for SUB.
  logic [ALU_W:0] alu_wide_c;

  always_comb begin
    alu_wide_c = '0;
    unique case (ALU_Sel)
      2'b00:   alu_wide_c = {1'b0, A | B};
      2'b01:   alu_wide_c = {1'b0, A} + {1'b0, B};
      2'b10:   alu_wide_c = {1'b0, A} - {1'b0, B};
      default: alu_wide_c = {1'b0, A & B};
    endcase
  end

  assign ALU_Out = alu_wide_c[ALU_W-1:0];

`ifdef ALU_FLAGS_EN
  assign alu_zero  = (alu_wide_c[ALU_W-1:0] == 16'h0000);
  assign alu_neg   = alu_wide_c[ALU_W-1];
  assign alu_carry = alu_wide_c[ALU_W];
`else
  logic unused_alu_carry;
  assign unused_alu_carry = alu_wide_c[ALU_W];
`endif

endmodule

// File: tb/tb_ram_alu_core.sv
// Directed testbench for ram_alu_core: RAM write/read/tri-state/reset
// behaviour and ALU results (plus flags when ALU_FLAGS_EN is defined).
// The bus has weak pull-ups, so a released bus reads as 16'hFFFF.
module tb_ram_alu_core;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data_w;
  logic          cs_input;
  logic          we;
  logic          oe;
  logic [15:0]   a_op;
  logic [15:0]   b_op;
  logic [1:0]    alu_sel;
  logic [15:0]   alu_out;
`ifdef ALU_FLAGS_EN
  logic          alu_zero;
  logic          alu_neg;
  logic          alu_carry;
`endif

  logic [DW-1:0] drv_val;
  logic          drv_en;

  int unsigned n_checks;
  int unsigned n_errors;

  assign data_w = drv_en ? drv_val : {DW{1'bz}};

  for (genvar gi = 0; gi < DW; gi++) begin : g_pu
    pullup (data_w[gi]);
  end

  ram_alu_core #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data_w),
    .cs_input (cs_input),
    .we       (we),
    .oe       (oe),
    .A        (a_op),
    .B        (b_op),
    .ALU_Sel  (alu_sel),
    .ALU_Out  (alu_out)
`ifdef ALU_FLAGS_EN
    ,
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg),
    .alu_carry(alu_carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    cs_input = 1'b1;
    we       = 1'b1;
    oe       = 1'b0;
    addr     = wa;
    drv_val  = wd;
    drv_en   = 1'b1;
    tick();
    drv_en   = 1'b0;
    we       = 1'b0;
  endtask

  task automatic alu_vec(input string tag, input logic [1:0] sel,
                         input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] exp_out, input logic exp_z,
                         input logic exp_n, input logic exp_c);
    alu_sel = sel;
    a_op    = va;
    b_op    = vb;
    #1;
    check_val({tag, "_out"}, 32'(alu_out), 32'(exp_out));
`ifdef ALU_FLAGS_EN
    check_val({tag, "_zero"},  32'(alu_zero),  32'(exp_z));
    check_val({tag, "_neg"},   32'(alu_neg),   32'(exp_n));
    check_val({tag, "_carry"}, 32'(alu_carry), 32'(exp_c));
`else
    if (exp_z & exp_n & exp_c) begin
      // Flags are not built in this configuration.
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    addr     = '0;
    cs_input = 1'b1;
    we       = 1'b0;
    oe       = 1'b1;
    drv_val  = '0;
    drv_en   = 1'b0;
    a_op     = '0;
    b_op     = '0;
    alu_sel  = 2'b00;

    // Reset clears the read register; bus shows it since cs/oe are active.
    tick();
    tick();
    rst = 1'b0;
    check_val("reset_rd", 32'(data_w), 32'h0000);

    // Writes, then reads with 1-edge latency.
    ram_write(18'h00100, 16'h0005);
    ram_write(18'h00102, 16'h0006);
    oe   = 1'b1;
    addr = 18'h00100;
    tick();
    check_val("rd_100", 32'(data_w), 32'h0005);
    addr = 18'h00102;
    tick();
    check_val("rd_102", 32'(data_w), 32'h0006);

    // Write with oe=0, then attempt read with cs_input=0.
    ram_write(18'h00104, 16'h1234);
    cs_input = 1'b0;
    oe       = 1'b1;
    addr     = 18'h00104;
    tick();
    check_val("cs0_hiz_a", 32'(data_w), 32'hFFFF);
    tick();
    check_val("cs0_hiz_b", 32'(data_w), 32'hFFFF);
    cs_input = 1'b1;
    #1;
    check_val("cs1_rd_hold", 32'(data_w), 32'h0006);
    tick();
    check_val("rd_104", 32'(data_w), 32'h1234);

    // Combinational turnaround.
    oe = 1'b0;
    #1;
    check_val("oe0_hiz", 32'(data_w), 32'hFFFF);
    oe = 1'b1;
    we = 1'b1;
    #1;
    check_val("we1_hiz", 32'(data_w), 32'hFFFF);
    we = 1'b0;
    #1;
    check_val("oe1_drive", 32'(data_w), 32'h1234);

    // Reset on a read edge, then memory still intact.
    addr = 18'h00100;
    rst  = 1'b1;
    tick();
    check_val("rst_mid_rd", 32'(data_w), 32'h0000);
    rst = 1'b0;
    tick();
    check_val("rd_after_rst", 32'(data_w), 32'h0005);

    // Write edge leaves rd_q untouched.
    ram_write(18'h00102, 16'hBEEF);
    oe = 1'b1;
    #1;
    check_val("wr_keeps_rd", 32'(data_w), 32'h0005);
    tick();
    check_val("rd_102_new", 32'(data_w), 32'hBEEF);

    // ALU vectors: tag, sel, A, B, out, zero, neg, carry.
    alu_vec("add_wrap", 2'b01, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    alu_vec("add_5_6",  2'b01, 16'h0005, 16'h0006, 16'h000B, 1'b0, 1'b0, 1'b0);
    alu_vec("add_neg",  2'b01, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    alu_vec("sub_bor",  2'b10, 16'h0005, 16'h0006, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    alu_vec("sub_eq",   2'b10, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0);
    alu_vec("sub_pos",  2'b10, 16'h0010, 16'h0003, 16'h000D, 1'b0, 1'b0, 1'b0);
    alu_vec("and",      2'b11, 16'h1010, 16'h1111, 16'h1010, 1'b0, 1'b0, 1'b0);
    alu_vec("or",       2'b00, 16'h1010, 16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0);
    alu_vec("or_neg",   2'b00, 16'h8000, 16'h0001, 16'h8001, 1'b0, 1'b1, 1'b0);
    alu_vec("and_zero", 2'b11, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
